// File: rtl/mm_pkg.sv
// mm_pkg: shared constants for the multi-port main-memory model.
//   - coherence status encodings (2 bits per line)
//   - FSM state constants and an equivalent enum type
//   - INIT pattern constants and helper functions for the init tag and the
//     post-access status of a line
package mm_pkg;

  // Coherence status of a line
  localparam logic [1:0] ST_INVALID   = 2'b00;
  localparam logic [1:0] ST_EXCLUSIVE = 2'b01;
  localparam logic [1:0] ST_SHARED    = 2'b10;
  localparam logic [1:0] ST_MODIFIED  = 2'b11;

  // Controller states
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_INIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  typedef enum logic [1:0] {
    MM_IDLE   = 2'd0,
    MM_INIT   = 2'd1,
    MM_ACCESS = 2'd2,
    MM_RESP   = 2'd3
  } mm_state_e;

  // INIT tag pattern: ((i mod PERIOD) + 1) * STEP
  localparam int INIT_TAG_STEP   = 32;
  localparam int INIT_TAG_PERIOD = 64;

  // Full-width init tag for line i; the caller truncates to its tag width.
  function automatic logic [31:0] init_tag(input logic [31:0] i);
    logic [31:0] t;
    t = ((i % 32'(INIT_TAG_PERIOD)) + 32'd1) * 32'(INIT_TAG_STEP);
    return t;
  endfunction

  // Status left in a line after an access: another cache holding a copy
  // forces SHARED; otherwise a read is EXCLUSIVE and a write MODIFIED.
  function automatic logic [1:0] next_status(input logic is_read,
                                             input logic others_snoop);
    logic [1:0] s;
    if (others_snoop) begin
      s = ST_SHARED;
    end else if (is_read) begin
      s = ST_EXCLUSIVE;
    end else begin
      s = ST_MODIFIED;
    end
    return s;
  endfunction

endpackage

// File: rtl/mm_multiport_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   i_req   - per-channel request vector
//   i_ptr   - last served channel; the search starts at i_ptr+1 (mod NCH)
//   o_gnt   - one-hot grant of the first asserted request found
//   o_idx   - binary index of the granted channel
//   o_valid - at least one request is asserted
// The pointer register itself lives in the parent.
module rr_arbiter #(
  parameter int NCH = 2,
  parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  output logic [NCH-1:0] o_gnt,
  output logic [PW-1:0]  o_idx,
  output logic           o_valid
);

  // Walk offsets from farthest to nearest so the nearest asserted request
  // after the pointer is the last (and therefore winning) assignment.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = NCH; k >= 1; k--) begin
      if (i_req[(int'(i_ptr) + k) % NCH]) begin
        o_gnt   = NCH'(1) << ((int'(i_ptr) + k) % NCH);
        o_idx   = PW'((int'(i_ptr) + k) % NCH);
        o_valid = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/mm_multiport.sv
// mm_multiport: main-memory model shared by NCH cache channels.
//   SCLK/SRST        - clock, synchronous active-high reset
//   SINT             - start the line-by-line initialisation sequence
//   req_i/rw_i       - per-channel request (level) and 1=read/0=write
//   snoop_i          - per-channel "my cache holds this line"
//   addr_i/data_i    - per-channel address and write data, packed by channel
//   data_o/tag_o     - read (or written) data, stored tag before update
//   status_o/hit_o   - new line status, tag match before update
//   gnt_o/DR         - one-hot served channel and one-cycle data-ready
//   busy_o           - high while initialising
// Per-line tag, data and status live in plain register arrays.
module mm_multiport
  import mm_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int DW   = 32,
  parameter int AW   = 24,
  parameter int IDXW = 8
) (
  input  logic                SCLK,
  input  logic                SRST,
  input  logic                SINT,
  input  logic [NCH-1:0]      req_i,
  input  logic [NCH-1:0]      rw_i,
  input  logic [NCH-1:0]      snoop_i,
  input  logic [NCH*AW-1:0]   addr_i,
  input  logic [NCH*DW-1:0]   data_i,
  output logic [DW-1:0]       data_o,
  output logic [AW-IDXW-1:0]  tag_o,
  output logic [1:0]          status_o,
  output logic                hit_o,
  output logic [NCH-1:0]      gnt_o,
  output logic                DR,
  output logic                busy_o
);

  localparam int TAGW  = AW - IDXW;
  localparam int DEPTH = 1 << IDXW;
  localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;

  logic [TAGW-1:0] r_tags [DEPTH];
  logic [DW-1:0]   r_data [DEPTH];
  logic [1:0]      r_stat [DEPTH];

  logic [1:0]      r_state;
  logic [IDXW-1:0] r_cnt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_win_idx;
  logic [NCH-1:0]  r_win_oh;
  logic            r_rw;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_osnoop;

  logic [NCH-1:0]  w_gnt;
  logic [PW-1:0]   w_gnt_idx;
  logic            w_gnt_valid;
  logic [IDXW-1:0] w_idx;
  logic [TAGW-1:0] w_req_tag;
  logic [TAGW-1:0] w_old_tag;
  logic [1:0]      w_new_status;
  logic [TAGW-1:0] w_init_tag;

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  assign w_idx        = r_addr[IDXW-1:0];
  assign w_req_tag    = r_addr[AW-1:IDXW];
  assign w_old_tag    = r_tags[w_idx];
  assign w_new_status = next_status(r_rw, r_osnoop);
  assign w_init_tag   = TAGW'(init_tag(32'(r_cnt)));

  // Line arrays: INIT fills one line per cycle, ACCESS updates the addressed
  // line. Contents survive reset; a reset edge simply suppresses the write.
  always_ff @(posedge SCLK) begin
    if (SRST) begin
      // no array write on a reset edge
    end else if (r_state == S_INIT) begin
      r_tags[r_cnt] <= w_init_tag;
      r_data[r_cnt] <= DW'(r_cnt);
      r_stat[r_cnt] <= ST_EXCLUSIVE;
    end else if (r_state == S_ACCESS) begin
      r_stat[w_idx] <= w_new_status;
      if (!r_rw) begin
        r_tags[w_idx] <= w_req_tag;
        r_data[w_idx] <= r_wdata;
      end else begin
        // reads leave tag and data untouched
      end
    end else begin
      // IDLE / RESP: arrays hold
    end
  end

  // Controller FSM, request capture, round-robin pointer and all outputs.
  always_ff @(posedge SCLK) begin
    if (SRST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ptr     <= PW'(NCH - 1);
      r_win_idx <= '0;
      r_win_oh  <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_osnoop  <= 1'b0;
      data_o    <= '0;
      tag_o     <= '0;
      status_o  <= 2'b00;
      hit_o     <= 1'b0;
      gnt_o     <= '0;
      DR        <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (SINT) begin
            // initialisation wins over any pending request
            r_state <= S_INIT;
            r_cnt   <= '0;
            busy_o  <= 1'b1;
          end else if (w_gnt_valid) begin
            r_state   <= S_ACCESS;
            r_win_idx <= w_gnt_idx;
            r_win_oh  <= w_gnt;
            r_rw      <= rw_i[w_gnt_idx];
            r_addr    <= addr_i[int'(w_gnt_idx)*AW +: AW];
            r_wdata   <= data_i[int'(w_gnt_idx)*DW +: DW];
            // other caches' copies decide SHARED vs exclusive ownership
            r_osnoop  <= |(snoop_i & ~w_gnt);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_INIT: begin
          if (r_cnt == IDXW'(DEPTH - 1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            busy_o  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + IDXW'(1);
          end
        end
        S_ACCESS: begin
          // tag_o/hit_o report the line as it was before this access
          data_o   <= r_rw ? r_data[w_idx] : r_wdata;
          tag_o    <= w_old_tag;
          hit_o    <= (w_old_tag == w_req_tag);
          status_o <= w_new_status;
          gnt_o    <= r_win_oh;
          DR       <= 1'b1;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          DR      <= 1'b0;
          gnt_o   <= '0;
          r_ptr   <= r_win_idx;
          r_state <= S_IDLE;
        end
        default: begin
          DR      <= 1'b0;
          gnt_o   <= '0;
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_multiport.sv
module tb_mm_multiport;

  localparam int NCH = 2;

  logic        SCLK = 1'b0;
  logic        SRST, SINT;
  logic [1:0]  req_i, rw_i, snoop_i;
  logic [47:0] addr_i;
  logic [63:0] data_i;
  logic [31:0] data_o;
  logic [15:0] tag_o;
  logic [1:0]  status_o;
  logic        hit_o;
  logic [1:0]  gnt_o;
  logic        DR, busy_o;

  int checks = 0;
  int errors = 0;

  // reference memory: what each line should hold
  logic [15:0] m_tag  [256];
  logic [31:0] m_data [256];
  int          m_ptr;

  mm_multiport #(.NCH(2), .DW(32), .AW(24), .IDXW(8)) dut (
    .SCLK(SCLK), .SRST(SRST), .SINT(SINT),
    .req_i(req_i), .rw_i(rw_i), .snoop_i(snoop_i),
    .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .tag_o(tag_o), .status_o(status_o), .hit_o(hit_o),
    .gnt_o(gnt_o), .DR(DR), .busy_o(busy_o)
  );

  always #5 SCLK = ~SCLK;

  task automatic check(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  task automatic model_init_lines(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      m_tag[i]  = 16'(((i % 64) + 1) * 32);
      m_data[i] = 32'(i);
    end
  endtask

  function automatic int pick_winner(input logic [1:0] rq);
    int w;
    w = -1;
    for (int k = 1; k <= NCH; k++) begin
      if (w < 0 && rq[(m_ptr + k) % NCH]) w = (m_ptr + k) % NCH;
    end
    return w;
  endfunction

  task automatic model_access(input int win, input bit rd, input logic [23:0] a,
                              input logic [31:0] d, input bit osn,
                              output logic [31:0] e_data, output logic [15:0] e_tag,
                              output logic e_hit, output logic [1:0] e_st);
    int ix;
    ix    = int'(a[7:0]);
    e_tag = m_tag[ix];
    e_hit = (m_tag[ix] == a[23:8]);
    if (rd) begin
      e_data = m_data[ix];
      e_st   = osn ? 2'b10 : 2'b01;
    end else begin
      m_data[ix] = d;
      m_tag[ix]  = a[23:8];
      e_data     = d;
      e_st       = osn ? 2'b10 : 2'b11;
    end
    m_ptr = win;
  endtask

  task automatic wait_dr(output int n);
    n = 0;
    do begin
      @(negedge SCLK);
      n++;
    end while (DR !== 1'b1 && n < 20);
  endtask

  task automatic check_idle_outputs(input string tg);
    check({tg, "_dr"},     64'(DR),       64'd0);
    check({tg, "_gnt"},    64'(gnt_o),    64'd0);
    check({tg, "_busy"},   64'(busy_o),   64'd0);
    check({tg, "_data"},   64'(data_o),   64'd0);
    check({tg, "_tag"},    64'(tag_o),    64'd0);
    check({tg, "_status"}, 64'(status_o), 64'd0);
    check({tg, "_hit"},    64'(hit_o),    64'd0);
  endtask

  // one served request: drive at a negedge with the DUT idle, expect DR two
  // negedges later, compare everything, drop req during the DR cycle
  task automatic serve(input string tg, input logic [1:0] rq, input logic [1:0] rw,
                       input logic [1:0] sn, input logic [47:0] a, input logic [63:0] d);
    int win, n;
    logic [31:0] e_data;
    logic [15:0] e_tag;
    logic        e_hit;
    logic [1:0]  e_st;
    win = pick_winner(rq);
    model_access(win, rw[win], a[win*24 +: 24], d[win*32 +: 32],
                 |(sn & ~(2'b01 << win)), e_data, e_tag, e_hit, e_st);
    rw_i = rw; snoop_i = sn; addr_i = a; data_i = d; req_i = rq;
    wait_dr(n);
    check({tg, "_latency"}, 64'(n),        64'd2);
    check({tg, "_gnt"},     64'(gnt_o),    64'(2'b01 << win));
    check({tg, "_data"},    64'(data_o),   64'(e_data));
    check({tg, "_tag"},     64'(tag_o),    64'(e_tag));
    check({tg, "_hit"},     64'(hit_o),    64'(e_hit));
    check({tg, "_status"},  64'(status_o), 64'(e_st));
    req_i = 2'b00;
    @(negedge SCLK);
    check({tg, "_dr_pulse"}, 64'(DR), 64'd0);
  endtask

  task automatic rd1(input string tg, input int ch, input logic [23:0] a, input logic [1:0] sn);
    serve(tg, 2'b01 << ch, 2'b11, sn, {a, a}, 64'd0);
  endtask

  task automatic wr1(input string tg, input int ch, input logic [23:0] a,
                     input logic [31:0] d, input logic [1:0] sn);
    serve(tg, 2'b01 << ch, 2'b00, sn, {a, a}, {d, d});
  endtask

  task automatic full_init(input string tg);
    int n;
    SINT = 1'b1;
    @(negedge SCLK);
    SINT = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 400) begin
      n++;
      @(negedge SCLK);
    end
    check({tg, "_busy_cycles"}, 64'(n), 64'd256);
    model_init_lines(0, 255);
  endtask

  initial begin
    int n, win, prev;
    logic [1:0]  rq, rw, sn;
    logic [47:0] a;
    logic [63:0] d;
    logic [7:0]  ix;
    logic [15:0] tg;
    logic [31:0] e_data;
    logic [15:0] e_tag;
    logic        e_hit;
    logic [1:0]  e_st;

    SRST = 1'b1; SINT = 1'b0; req_i = 2'b00; rw_i = 2'b00; snoop_i = 2'b00;
    addr_i = '0; data_i = '0;
    m_ptr = NCH - 1;
    repeat (2) @(negedge SCLK);
    check_idle_outputs("reset");
    SRST = 1'b0;
    @(negedge SCLK);

    full_init("init1");
    rd1("line0",  0, 24'h002000, 2'b00);
    rd1("line63", 0, 24'h08003F, 2'b00);
    rd1("line64", 0, 24'h002040, 2'b00);
    rd1("rd5",    0, 24'h002005, 2'b00);
    wr1("wr5",    1, 24'h123405, 32'hDEADBEEF, 2'b01);
    rd1("rd5b",   0, 24'h123405, 2'b00);
    wr1("wr_nosnp", 0, 24'h004007, 32'h0BADF00D, 2'b00);
    rd1("rd_snp",   1, 24'h004007, 2'b01);

    // both channels hold requests for four services
    rq = 2'b11; rw = 2'b11; sn = 2'b00;
    a = {24'h00200B, 24'h00200A}; d = 64'd0;
    rw_i = rw; snoop_i = sn; addr_i = a; data_i = d; req_i = rq;
    prev = 0;
    for (int s = 0; s < 4; s++) begin
      win = pick_winner(rq);
      model_access(win, 1'b1, a[win*24 +: 24], 32'd0, 1'b0, e_data, e_tag, e_hit, e_st);
      wait_dr(n);
      check("rr_gap",  64'(n), (s == 0) ? 64'd2 : 64'd3);
      check("rr_gnt",  64'(gnt_o),  64'(2'b01 << win));
      check("rr_data", 64'(data_o), 64'(e_data));
      if (s == 3) req_i = 2'b00;
    end
    @(negedge SCLK);

    // randomized traffic on a handful of lines
    for (int it = 0; it < 40; it++) begin
      rq = 2'($urandom_range(1, 3));
      rw = 2'($urandom_range(0, 3));
      sn = 2'($urandom_range(0, 3));
      for (int c = 0; c < 2; c++) begin
        ix = 8'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
          0:       tg = 16'(((int'(ix) % 64) + 1) * 32);
          1:       tg = 16'h1234;
          default: tg = 16'($urandom);
        endcase
        a[c*24 +: 24] = {tg, ix};
        d[c*32 +: 32] = $urandom;
      end
      serve("rand", rq, rw, sn, a, d);
    end

    // reset in the middle of INIT
    wr1("pre150", 0, 24'h0ABC96, 32'h00150150, 2'b00);
    wr1("pre100", 1, 24'h0ABC64, 32'h00100100, 2'b00);
    SINT = 1'b1;
    @(negedge SCLK);
    SINT = 1'b0;
    repeat (100) @(negedge SCLK);
    check("midinit_busy", 64'(busy_o), 64'd1);
    SRST = 1'b1;
    @(negedge SCLK);
    check_idle_outputs("abort");
    SRST = 1'b0;
    model_init_lines(0, 99);
    m_ptr = NCH - 1;
    @(negedge SCLK);
    rd1("keep150", 0, 24'h0ABC96, 2'b00);
    rd1("keep100", 0, 24'h0ABC64, 2'b00);
    rd1("init99",  1, 24'h048063, 2'b00);

    full_init("init2");
    rd1("re100", 0, 24'h0ABC64, 2'b00);
    rd1("re150", 1, 24'h02E096, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
